// File: rtl/isa_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isa_io_pkg
// Description : Shared types, constants and the I/O window decode used by the
//               ISA I/O-bus front end.
//               - state_t       : front-end control states
//               - RDATA_TIMEOUT : read data returned to the host on a timeout
//               - hit_decode()  : base-address window match on raw bus pins
// Revision    : 1.0 - initial release
// ============================================================================
package isa_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;

    // Match A[15:addr_w] against BASE[15:addr_w]. A mask is used instead of a
    // part-select so the window width can be a run-time argument.
    // DMA cycles (AEN high) never decode as I/O.
    function automatic logic hit_decode(
        input logic [15:0] a,
        input logic        aen,
        input logic [15:0] base,
        input int          addr_w
    );
        logic [15:0] mask;
        mask = 16'hFFFF << addr_w;
        return !aen && ((a & mask) == (base & mask));
    endfunction

endpackage
`default_nettype wire

// File: rtl/strobe_sync.sv
`default_nettype none
// ============================================================================
// Module      : strobe_sync
// Description : Two-flop synchroniser for an asynchronous active-low strobe,
//               followed by a falling-edge detector.
// Ports       : clk        - system clock
//               rst_n      - synchronous active-low reset
//               i_strobe_n - raw asynchronous strobe (active low)
//               o_start    - high for one cycle after a synchronised fall
//               o_level_n  - synchronised strobe level (low = asserted)
// Revision    : 1.0 - initial release
// ============================================================================
module strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_strobe_n,
    output logic o_start,
    output logic o_level_n
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = i_strobe_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    // All stages reset to the asserted (low) level, so a strobe that is
    // already low when reset releases never looks like a falling edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    // Pin falls before edge 1, sync2 goes low at edge 2, so the consumer acts
    // on the start at edge 3.
    assign o_start   = prev_q && !sync2_q;
    assign o_level_n = sync2_q;

endmodule
`default_nettype wire

// File: rtl/isa_io_frontend.sv
`default_nettype none
// ============================================================================
// Module      : isa_io_frontend
// Description : ISA I/O-bus front end. Synchronises IOWR/IORD, decodes a
//               2**ADDR_W byte window at BASE, issues one single-cycle
//               register access per bus cycle, holds WAIT low until the
//               peripheral acknowledges (or a timeout expires) and steers
//               the data-bus direction.
// Ports       : CLK, RST_N          - clock, synchronous active-low reset
//               A, AEN              - ISA address and DMA address enable
//               IOWR, IORD          - raw asynchronous I/O strobes (low)
//               D_in, D_out, DDIR   - host data in/out and drive enable
//               WAIT                - ISA ready (0 extends the cycle)
//               P_ADDR, P_WDATA     - peripheral register address / data
//               P_WR, P_RD          - one-cycle peripheral requests
//               P_RDATA, P_ACK      - peripheral read data / completion
//               TO_ERR              - sticky: last access timed out
// Revision    : 1.0 - initial release
// ============================================================================
module isa_io_frontend
    import isa_io_pkg::*;
#(
    parameter logic [15:0] BASE    = 16'h0300,
    parameter int          ADDR_W  = 2,
    parameter int          TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [15:0]       A,
    input  logic              AEN,
    input  logic              IOWR,
    input  logic              IORD,
    input  logic [7:0]        D_in,
    output logic [7:0]        D_out,
    output logic              DDIR,
    output logic              WAIT,
    output logic [ADDR_W-1:0] P_ADDR,
    output logic [7:0]        P_WDATA,
    output logic              P_WR,
    output logic              P_RD,
    input  logic [7:0]        P_RDATA,
    input  logic              P_ACK,
    output logic              TO_ERR
);

    // Last counter value of an un-acknowledged access; ACCESS therefore
    // lasts at most TIMEOUT cycles.
    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    logic w_wr_start, w_wr_level_n;
    logic w_rd_start, w_rd_level_n;
    logic w_hit;

    state_t              state_q,   state_d;
    logic [7:0]          cnt_q,     cnt_d;
    logic                is_rd_q,   is_rd_d;
    logic [7:0]          d_out_q,   d_out_d;
    logic [ADDR_W-1:0]   p_addr_q,  p_addr_d;
    logic [7:0]          p_wdata_q, p_wdata_d;
    logic                p_wr_q,    p_wr_d;
    logic                p_rd_q,    p_rd_d;
    logic                to_err_q,  to_err_d;

    // ------------------------------------------------------------------
    // Strobe synchronisers
    // ------------------------------------------------------------------
    strobe_sync u_wr_sync (
        .clk        (CLK),
        .rst_n      (RST_N),
        .i_strobe_n (IOWR),
        .o_start    (w_wr_start),
        .o_level_n  (w_wr_level_n)
    );

    strobe_sync u_rd_sync (
        .clk        (CLK),
        .rst_n      (RST_N),
        .i_strobe_n (IORD),
        .o_start    (w_rd_start),
        .o_level_n  (w_rd_level_n)
    );

    // Decode is taken from the raw pins; A and AEN are stable well before
    // the strobes fall, so the value seen at the synchronised start matches.
    assign w_hit = hit_decode(A, AEN, BASE, ADDR_W);

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_rd_d   = is_rd_q;
        d_out_d   = d_out_q;
        p_addr_d  = p_addr_q;
        p_wdata_d = p_wdata_q;
        p_wr_d    = 1'b0;
        p_rd_d    = 1'b0;
        to_err_d  = to_err_q;

        case (state_q)
            IDLE: begin
                if (w_wr_start && w_rd_start) begin
                    // Ambiguous cycle: no access, just wait for release.
                    state_d = DONE;
                end else if (w_wr_start && w_hit) begin
                    p_addr_d  = A[ADDR_W-1:0];
                    p_wdata_d = D_in;
                    p_wr_d    = 1'b1;
                    is_rd_d   = 1'b0;
                    cnt_d     = 8'd0;
                    state_d   = ACCESS;
                end else if (w_rd_start && w_hit) begin
                    p_addr_d  = A[ADDR_W-1:0];
                    p_rd_d    = 1'b1;
                    is_rd_d   = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = ACCESS;
                end
            end

            ACCESS: begin
                // The request pulse is live during the first ACCESS cycle,
                // so a same-cycle acknowledge is honoured here as well.
                if (P_ACK) begin
                    if (is_rd_q) begin
                        d_out_d = P_RDATA;
                    end
                    to_err_d = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == c_cnt_last) begin
                    if (is_rd_q) begin
                        d_out_d = RDATA_TIMEOUT;
                    end
                    to_err_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            DONE: begin
                if (w_wr_level_n && w_rd_level_n) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            is_rd_q   <= 1'b0;
            d_out_q   <= 8'hFF;
            p_addr_q  <= '0;
            p_wdata_q <= 8'h00;
            p_wr_q    <= 1'b0;
            p_rd_q    <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_rd_q   <= is_rd_d;
            d_out_q   <= d_out_d;
            p_addr_q  <= p_addr_d;
            p_wdata_q <= p_wdata_d;
            p_wr_q    <= p_wr_d;
            p_rd_q    <= p_rd_d;
            to_err_q  <= to_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The raw-pin term pulls WAIT low immediately, covering the cycles the
    // synchroniser needs before the state machine sees the strobe.
    assign WAIT    = !(w_hit && (!IOWR || !IORD) && (state_q != DONE));
    assign DDIR    = w_hit && !IORD && IOWR;
    assign D_out   = d_out_q;
    assign P_ADDR  = p_addr_q;
    assign P_WDATA = p_wdata_q;
    assign P_WR    = p_wr_q;
    assign P_RD    = p_rd_q;
    assign TO_ERR  = to_err_q;

endmodule
`default_nettype wire
